// File: rtl/spin_update.sv
// spin_update: consumer end of the Ising sampler's local-field interface.
// Accepts N packed signed local fields, then updates one spin per cycle
// (sign of field + noise; a zero sum keeps the spin), and presents the new
// spin vector over a valid/ready handshake.
// Optional feature macro: SPIN_NOISE_EN (adds LFSR thermal noise; when
// undefined the update is a deterministic zero-temperature descent).
module spin_update #(
    parameter int          N          = 4,
    parameter int          DATABITS   = 16,
    parameter logic [N-1:0] INIT_SPINS = 4'b0101,
    parameter int          TEMP_SHIFT = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATABITS*N-1:0] field_data,
    input  logic                  field_valid,
    output logic                  field_ready,
    output logic [N-1:0]          spins_out,
    output logic                  spins_valid,
    input  logic                  spins_ready,
    input  logic [N-1:0]          spin_init,
    input  logic                  init_load,
    output logic [15:0]           sweep_count
);

    // Sum width: one field plus one noise sample can never overflow this.
    localparam int SW = DATABITS + 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, UPDATE, PRESENT} state_t;

    state_t                     state_reg;
    logic [KW-1:0]              k_reg;
    logic [N-1:0]               spins_reg;
    logic                       valid_reg;
    logic [15:0]                count_reg;
    logic signed [DATABITS-1:0] fields_reg [N];
    logic signed [DATABITS-1:0] field_vec  [N];
    logic signed [SW-1:0]       noise;
    logic signed [SW-1:0]       sum;
    logic                       sum_pos;
    logic                       sum_neg;

    // Unpack the flat field bus into one signed element per spin.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign field_vec[gi] = field_data[gi*DATABITS +: DATABITS];
        end
    endgenerate

`ifdef SPIN_NOISE_EN
    logic [15:0]        lfsr_reg;
    logic signed [15:0] lfsr_scaled;

    // Larger TEMP_SHIFT shrinks the noise amplitude (lower temperature).
    assign lfsr_scaled = $signed(lfsr_reg) >>> TEMP_SHIFT;
    assign noise       = SW'(lfsr_scaled);

    // Galois LFSR, taps 0xB400, stepped once for every spin update.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (state_reg == UPDATE) begin
            lfsr_reg <= lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
        end
    end
`else
    assign noise = '0;

    // Noise parameters have no effect in the deterministic build.
    if ((TEMP_SHIFT < 0) || (LFSR_SEED == 16'h0000)) begin : g_noise_params_unused
    end
`endif

    assign sum     = SW'(fields_reg[k_reg]) + noise;
    assign sum_neg = sum[SW-1];
    assign sum_pos = !sum[SW-1] && (sum != '0);

    assign field_ready = (state_reg == IDLE) && !init_load;
    assign spins_out   = spins_reg;
    assign spins_valid = valid_reg;
    assign sweep_count = count_reg;

    // Control FSM: accept fields, sweep spins 0..N-1, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            spins_reg <= INIT_SPINS;
            valid_reg <= 1'b0;
            count_reg <= 16'h0000;
            k_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (init_load) begin
                        spins_reg <= spin_init;
                    end else if (field_valid) begin
                        fields_reg <= field_vec;
                        k_reg      <= '0;
                        state_reg  <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (sum_pos) begin
                        spins_reg[k_reg] <= 1'b1;
                    end else if (sum_neg) begin
                        spins_reg[k_reg] <= 1'b0;
                    end
                    if (k_reg == KW'(N - 1)) begin
                        state_reg <= PRESENT;
                        valid_reg <= 1'b1;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                PRESENT: begin
                    if (spins_ready) begin
                        valid_reg <= 1'b0;
                        count_reg <= count_reg + 16'h0001;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spin_update.sv
// Self-checking bench for spin_update: a sweep-level model (final spins are
// resolved as a whole when fields are accepted) is compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_spin_update;
    localparam int N  = 4;
    localparam int DB = 16;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic [DB*N-1:0] field_data = '0;
    logic          field_valid = 1'b0;
    logic          field_ready;
    logic [N-1:0]  spins_out;
    logic          spins_valid;
    logic          spins_ready = 1'b0;
    logic [N-1:0]  spin_init   = '0;
    logic          init_load   = 1'b0;
    logic [15:0]   sweep_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    spin_update #(
        .N(N), .DATABITS(DB), .INIT_SPINS(4'b0101), .TEMP_SHIFT(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .field_data(field_data), .field_valid(field_valid),
        .field_ready(field_ready), .spins_out(spins_out), .spins_valid(spins_valid),
        .spins_ready(spins_ready), .spin_init(spin_init), .init_load(init_load),
        .sweep_count(sweep_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_spins   = 4'b0101;
    int           m_busy    = 0;
    bit           m_present = 1'b0;
    logic [15:0]  m_count   = 16'h0;
    logic [15:0]  m_lfsr    = 16'hACE1;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_spins = 4'b0101; m_busy = 0; m_present = 1'b0;
                m_count = 16'h0;   m_lfsr = 16'hACE1;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_present = 1'b1;
            end else if (m_present) begin
                if (spins_ready) begin
                    m_present = 1'b0;
                    m_count++;
                end
            end else if (init_load) begin
                m_spins = spin_init;
            end else if (field_valid) begin
                for (int k = 0; k < N; k++) begin
                    int total;
                    total = int'($signed(field_data[k*DB +: DB]));
`ifdef SPIN_NOISE_EN
                    total += int'($signed(m_lfsr)) >>> 4;
                    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
                    else           m_lfsr = m_lfsr >> 1;
`endif
                    if (total > 0)      m_spins[k] = 1'b1;
                    else if (total < 0) m_spins[k] = 1'b0;
                end
                m_busy = N;
            end
        end
    end

    // Every-cycle comparison against the model, sampled after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (cmp_en) begin
                check("field_ready", 32'(field_ready), 32'(m_busy == 0 && !m_present && !init_load));
                check("spins_valid", 32'(spins_valid), 32'(m_present));
                check("sweep_count", 32'(sweep_count), 32'(m_count));
                if (m_busy == 0) check("spins_out", 32'(spins_out), 32'(m_spins));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [DB*N-1:0] f);
        field_data  = f;
        field_valid = 1'b1;
        @(negedge clk);
        field_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!spins_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!spins_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: spins_valid=0 after %0d cycles want 1", n);
        end
    endtask

    task automatic handshake();
        spins_ready = 1'b1;
        @(negedge clk);
        spins_ready = 1'b0;
        $display("sweep done: spins=%b sweep_count=%0d", spins_out, sweep_count);
    endtask

`ifdef SPIN_NOISE_EN
    logic [N-1:0] seq_a [64];
    logic [N-1:0] seen0 = '0;
    logic [N-1:0] seen1 = '0;
`endif

    int n;

    initial begin
        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset spins_out", 32'(spins_out), 32'h5);
        check("reset field_ready", 32'(field_ready), 32'h1);
        check("reset spins_valid", 32'(spins_valid), 32'h0);
        check("reset sweep_count", 32'(sweep_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sweep: fields k0..k3 = 3, -2, 0, 7.
        send({16'd7, 16'd0, 16'hFFFE, 16'd3});
        wait_valid(n);
        check("latency", 32'(n), 32'd4);
`ifndef SPIN_NOISE_EN
        check("basic spins", 32'(spins_out), 32'hD);
`endif
        handshake();
        check("basic count", 32'(sweep_count), 32'd1);
        check("basic ready", 32'(field_ready), 32'd1);

        // Backpressure: k0..k3 = -5, 9, -1, 0 -> 1010 from 1101.
        send({16'd0, 16'hFFFF, 16'd9, 16'hFFFB});
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            field_valid = i[0];
            field_data  = {4{16'h0011}};
            @(negedge clk);
`ifndef SPIN_NOISE_EN
            check("bp spins", 32'(spins_out), 32'hA);
`endif
            check("bp valid", 32'(spins_valid), 32'd1);
            check("bp ready", 32'(field_ready), 32'd0);
        end
        field_valid = 1'b0;
        handshake();
        check("bp count", 32'(sweep_count), 32'd2);

        // Preload wins over a simultaneous field_valid.
        init_load   = 1'b1;
        spin_init   = 4'b0000;
        field_valid = 1'b1;
        field_data  = {4{16'h0005}};
        @(negedge clk);
        check("preload spins", 32'(spins_out), 32'h0);
        check("preload ready", 32'(field_ready), 32'd0);
        init_load = 1'b0;
        // Extremes: k0=0x7FFF, k1=0x8000, k2=1, k3=0xFFFF -> 0101.
        send({16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF});
        wait_valid(n);
`ifndef SPIN_NOISE_EN
        check("extreme spins", 32'(spins_out), 32'h5);
`endif
        handshake();
        check("extreme count", 32'(sweep_count), 32'd3);

        // Reset in the middle of a sweep (k == 2).
        send({4{16'h0001}});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst spins", 32'(spins_out), 32'h5);
        check("midrst count", 32'(sweep_count), 32'h0);
        check("midrst valid", 32'(spins_valid), 32'h0);
        check("midrst ready", 32'(field_ready), 32'h1);
        @(negedge clk);

`ifdef SPIN_NOISE_EN
        // Noise: zero fields, 64 sweeps, then repeat from reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send('0);
            wait_valid(n);
            seq_a[i] = spins_out;
            seen0 |= ~spins_out;
            seen1 |= spins_out;
            handshake();
        end
        check("noise seen0", 32'(seen0), 32'hF);
        check("noise seen1", 32'(seen1), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send('0);
            wait_valid(n);
            check("noise repeat", 32'(spins_out), 32'(seq_a[i]));
            handshake();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
